// File: rtl/clk_period_meter_if.sv
// Measurement result bundle of clk_period_meter: the meter drives it (master)
// and the consumer that watches the divider output reads it (slave).
interface clk_period_meter_if #(
    parameter int CNT_W = 24
);
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    modport master (output period, high_time, meas_valid, locked, timeout);
    modport slave  (input  period, high_time, meas_valid, locked, timeout);
endinterface

// File: rtl/clk_period_meter.sv
// Brings a slow divider clock into the clk_MHz domain, measures its period and
// high time in clk_MHz cycles, and reports lock against EXPECTED and clock loss.
module clk_period_meter #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int EXPECTED    = 500000,
    parameter int TOL         = 500,
    parameter int LOCK_COUNT  = 2,
    parameter int TIMEOUT     = 1000000
) (
    input  logic               clk_MHz,
    input  logic               reset,
    input  logic               clk_in,
    clk_period_meter_if.master meas
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hcnt_q, hcnt_d;
    logic [CNT_W-1:0]       hpend_q;
    logic                   fell_q;
    logic [GOOD_W-1:0]      good_q, good_inc;
    logic [CNT_W-1:0]       period_q, high_time_q;
    logic                   meas_valid_q, locked_q, timeout_q;

    logic                   rise, fall, in_tol;
    logic [CNT_W-1:0]       high_cap;
    logic signed [CNT_W:0]  diff, abs_diff;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        rise     = lvl_q & ~prev_q;
        fall     = ~lvl_q & prev_q;
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        hcnt_d   = (fell_q || fall || hcnt_q == '1) ? hcnt_q : hcnt_q + CNT_W'(1);
        if (rise) begin
            cnt_d  = CNT_W'(1);
            hcnt_d = CNT_W'(1);
        end
        // Without a fall in this period the frozen-less hcnt equals the full period.
        high_cap = fell_q ? hpend_q : hcnt_q;
        diff     = $signed({1'b0, cnt_q}) - $signed((CNT_W+1)'(EXPECTED));
        abs_diff = diff[CNT_W] ? -diff : diff;
        in_tol   = (abs_diff <= $signed((CNT_W+1)'(TOL)));
        good_inc = (good_q == GOOD_W'(LOCK_COUNT)) ? good_q : good_q + GOOD_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_MHz or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            lvl_q        <= 1'b0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            hpend_q      <= '0;
            fell_q       <= 1'b0;
            good_q       <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], clk_in};
            lvl_q        <= sync_q[SYNC_STAGES-1];
            prev_q       <= lvl_q;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            meas_valid_q <= 1'b0;

            if (rise) begin
                fell_q <= 1'b0;
            end else if (fall) begin
                fell_q  <= 1'b1;
                hpend_q <= hcnt_q;
            end

            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q   <= ARM;
                        timeout_q <= 1'b0;
                    end
                end
                ARM, MEASURE: begin
                    // A rise on the timeout cycle wins: it is a normal capture.
                    if (rise) begin
                        state_q      <= MEASURE;
                        period_q     <= cnt_q;
                        high_time_q  <= high_cap;
                        meas_valid_q <= 1'b1;
                        if (in_tol) begin
                            good_q   <= good_inc;
                            locked_q <= (good_inc == GOOD_W'(LOCK_COUNT));
                        end else begin
                            good_q   <= '0;
                            locked_q <= 1'b0;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                        good_q    <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign meas.period     = period_q;
    assign meas.high_time  = high_time_q;
    assign meas.meas_valid = meas_valid_q;
    assign meas.locked     = locked_q;
    assign meas.timeout    = timeout_q;
endmodule
